// File: rtl/grid_scanout.sv
// grid_scanout: raster timing plus 2-stage scanout of a 1-bit cell grid.
// The grid is latched into a shadow copy at vblank start so frames never tear.
module grid_scanout #(
  parameter int          GRID_ROWS = 30,
  parameter int          GRID_COLS = 40,
  parameter int          CELL_SIZE = 8,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 32,
  parameter int          H_BP      = 32,
  parameter int          V_FP      = 4,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 12,
  parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           pix_en,
  input  logic [GRID_ROWS*GRID_COLS-1:0] grid_ram,
  output logic [23:0]                    vid_rgb,
  output logic                           vid_de,
  output logic                           vid_hs,
  output logic                           vid_vs,
  output logic                           vblank_start
);

  localparam int N      = GRID_ROWS * GRID_COLS;
  localparam int H_ACT  = GRID_COLS * CELL_SIZE;
  localparam int V_ACT  = GRID_ROWS * CELL_SIZE;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int CS_LOG = $clog2(CELL_SIZE);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SNAP = VW'(V_ACT);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          de;
    logic          hs;
    logic          vs;
  } s1_t;

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [N-1:0]  r_shadow;
  s1_t           r_s1;
  logic [23:0]   r_rgb;
  logic          r_de;
  logic          r_hs;
  logic          r_vs;
  logic          r_vb;

  int            w_h;
  int            w_v;
  s1_t           w_s1;
  logic          w_snap;

  always_comb begin
    w_h       = int'(r_h);
    w_v       = int'(r_v);
    w_s1      = '0;
    w_s1.de   = (w_h < H_ACT) && (w_v < V_ACT);
    w_s1.hs   = (w_h >= H_ACT + H_FP) && (w_h < H_ACT + H_FP + H_SYNC);
    w_s1.vs   = (w_v >= V_ACT + V_FP) && (w_v < V_ACT + V_FP + V_SYNC);
    // Index is only meaningful inside the active area; keep it 0 elsewhere.
    if (w_s1.de)
      w_s1.idx = IW'((w_v >> CS_LOG) * GRID_COLS + (w_h >> CS_LOG));
    w_snap    = (r_h == '0) && (r_v == V_SNAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pix_en) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_vb     <= 1'b0;
    end else begin
      r_vb <= 1'b0;
      if (pix_en && w_snap) begin
        r_shadow <= grid_ram;
        r_vb     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1  <= '0;
      r_rgb <= '0;
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else if (pix_en) begin
      r_s1  <= w_s1;
      r_rgb <= !r_s1.de ? 24'h0 :
               (r_shadow[r_s1.idx] ? FG_COLOR : BG_COLOR);
      r_de  <= r_s1.de;
      r_hs  <= r_s1.hs;
      r_vs  <= r_s1.vs;
    end
  end

  assign vid_rgb      = r_rgb;
  assign vid_de       = r_de;
  assign vid_hs       = r_hs;
  assign vid_vs       = r_vs;
  assign vblank_start = r_vb;

endmodule

// File: doc/grid_scanout.md
Name: grid_scanout

Overview:
- Reader side of the 1-bit-per-cell character/pixel grid bus driven by the grid writer logic.
- Generates raster timing and scans the grid out as 24-bit RGB video with DE/HS/VS, for the Pocket video output path.
- Snapshots the grid once per frame at vblank start so mid-frame writes never tear.
- Each cell is drawn as a CELL_SIZE x CELL_SIZE block of pixels.

Parameters:
- GRID_ROWS, 30, number of cell rows.
- GRID_COLS, 40, number of cell columns.
- CELL_SIZE, 8, pixels per cell edge; must be a power of two; H_ACTIVE=GRID_COLS*CELL_SIZE, V_ACTIVE=GRID_ROWS*CELL_SIZE.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 32, HS width (pixels).
- H_BP, 32, horizontal back porch (pixels).
- V_FP, 4, vertical front porch (lines).
- V_SYNC, 4, VS width (lines).
- V_BP, 12, vertical back porch (lines).
- FG_COLOR, 24'hFFFFFF, RGB for cell bit = 1.
- BG_COLOR, 24'h000000, RGB for cell bit = 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- pix_en  in  1  pixel strobe; all timing state advances only when high.
- grid_ram  in  GRID_ROWS*GRID_COLS  cell bits, index = row*GRID_COLS+col.
- vid_rgb  out  24  pixel colour; BG-independent 0 outside DE.
- vid_de  out  1  active-video enable.
- vid_hs  out  1  horizontal sync, active high.
- vid_vs  out  1  vertical sync, active high.
- vblank_start  out  1  one-clk pulse when the snapshot is taken.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset: h_cnt, v_cnt, shadow grid and all pipeline registers go to 0. vid_rgb=0, vid_de=0, vid_hs=0, vid_vs=0, vblank_start=0.
- Reset asserted mid-frame aborts the frame immediately; after release, scanning restarts at (0,0).
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (400 default). V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (260 default).
- Counter advance, on each clk with pix_en=1:
  - h_cnt increments.
  - At h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt=V_TOTAL-1 with the horizontal wrap, v_cnt wraps to 0.
- Raw timing per (h,v):
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line.
- Pipeline is 2 stages, clocked only on pix_en:
  - Stage 1 registers the cell index (v/CELL_SIZE)*GRID_COLS + h/CELL_SIZE (shifts; row*GRID_COLS by multiply is allowed) plus raw de/hs/vs.
  - Stage 2 reads shadow[index] and registers vid_rgb (FG_COLOR or BG_COLOR when de, else 0) plus the delayed de/hs/vs.
  - Net latency: outputs for position (h,v) appear 2 pix_en strobes after the counters hold (h,v). All outputs are mutually aligned.
  - The index is only evaluated when de is set; the index is never out of range when de is set.
- Snapshot: on the clk where pix_en=1 and (h_cnt,v_cnt)=(0,V_ACTIVE), shadow <= grid_ram and vblank_start=1 for that single clk. Otherwise vblank_start=0.
- Display uses only shadow. grid_ram changes become visible from the next frame's first line. Frame 0 after reset shows all BG.
- pix_en=0: counters, pipeline, outputs and shadow hold. vblank_start stays 0.
- No combinational path from any input to any output.

Test Plan:
- Reset with pix_en held 1 for 2 clk -> all outputs 0. First strobes after release: de rises exactly 2 strobes after the first pix_en, vid_rgb=BG_COLOR.
- grid_ram[0]=1, run to the 2nd frame -> pixels (0..7, 0..7) = FFFFFF, pixel (8,0)=000000, pixel (0,8)=000000.
- grid_ram[39]=1 and grid_ram[1199]=1 -> FG at x=312..319 on lines 0..7, and at x=312..319 on lines 232..239. Pixel (311,0)=BG.
- Count strobes per line and per frame -> de high 320 of 400 per line. HS high for 32 strobes, starting 336 strobes after line start (pipeline-delayed). VS high 4 lines. 240 DE lines per 260.
- Set grid_ram[5]=1 at v_cnt=100 of frame N -> no FG in frame N. vblank_start pulses once at (0,240). Cell 5 is FG in frame N+1.
- pix_en toggling 1-in-4 plus a mid-frame reset pulse -> output sequence identical to the continuous run, slowed 4x. Immediately after reset: outputs 0, counters restart at (0,0).
